restador_serial_n: RTL
======================

RESTADOR_SERIAL_N -- requirements
Module: restador_serial_n

Interface
REQ-001 The block SHALL take parameter n, default 4, meaning operand and result width in bits (n >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, n bits: minuend, sampled only on an accepted start.
REQ-006 The block SHALL have port B, input, n bits: subtrahend, sampled only on an accepted start.
REQ-007 The block SHALL have port res, output, n bits: registered difference A-B modulo 2^n.
REQ-008 The block SHALL have port baOut, output, 1 bit: final borrow out; 1 when A < B unsigned.
REQ-009 The block SHALL have port N, output, 1 bit: res[n-1].
REQ-010 The block SHALL have port Z, output, 1 bit: 1 when res == 0.
REQ-011 The block SHALL have port V, output, 1 bit: signed overflow of A-B.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the outputs are valid.

Function
REQ-014 The block SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL latch A and B into shift registers, clear the internal borrow and bit counter, and enter SHIFT.
REQ-016 In SHIFT, each cycle the block SHALL process one bit, LSB first.
- Difference bit: d = a ^ b ^ br.
- Next borrow: br' = (~a & b) | (~(a ^ b) & br).
- d SHALL be shifted into a partial-result register from the MSB side.
REQ-017 SHIFT SHALL last exactly n cycles, counted by a ceil(log2(n+1))-bit counter; after the nth bit the FSM SHALL enter DONE.
REQ-018 On entry to DONE, res, baOut, N, Z and V SHALL update together from the final partial result and borrow.
REQ-019 The block SHALL compute V as (A[n-1] != B[n-1]) && (res[n-1] != A[n-1]), using the latched operands.
REQ-020 Timing SHALL be: start accepted at edge k; busy=1 during cycles k+1..k+n; done=1 and busy=0 in cycle k+n+1 only.
REQ-021 DONE SHALL return to IDLE after one cycle unless start=1, in which case a new operation SHALL begin (back-to-back throughput: one result per n+1 cycles).
REQ-022 The block SHALL ignore start while in SHIFT, and changes to A/B during SHIFT SHALL NOT affect the result.
REQ-023 res and the flags SHALL hold their last values in IDLE and during a following SHIFT until the next DONE.
REQ-024 done SHALL never be high in the same cycle as busy.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE and clear res, baOut, N, V, busy, done, the counter, the borrow and the shift registers to 0, and set Z to 1.
REQ-026 rst SHALL take priority over start.
REQ-027 Reset during SHIFT SHALL abort the operation with no done pulse and leave the outputs at their reset values.

Verification (n=4)
REQ-028 The bench SHALL drive A=0011, B=0010, start pulse -> res=0001, baOut=0, N=0, Z=0, V=0, with done exactly 5 cycles after the start edge.
REQ-029 The bench SHALL drive A=0010, B=0011 -> res=1111, baOut=1, N=1, Z=0, V=0.
REQ-030 The bench SHALL drive A=0111, B=1000 -> res=1111, baOut=1, N=1, V=1 (7 - (-8) overflows).
REQ-031 The bench SHALL drive A=0011, B=0011 -> res=0000, Z=1, baOut=0; then, with start held in the DONE cycle, A=1001, B=1010 -> res=1111, baOut=1, done exactly 5 cycles later.
REQ-032 The bench SHALL pulse start with A=1110, B=1111, then pulse start again with A=0000, B=0001 two cycles later -> the second start is ignored and res=1111, baOut=1.
REQ-033 The bench SHALL assert rst in the 2nd SHIFT cycle -> no done pulse, busy=0, res=0000, Z=1 from the next cycle.

Source files
------------

// File: rtl/restador_serial_n.sv
// Bit-serial n-bit subtractor (LSB first) with N/Z/V/borrow flags; n+1 cycles from start to done.
// No backpressure: start is ignored while busy, and a start held in the done cycle chains the next operation.
module restador_serial_n #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] res,
  output logic         baOut,
  output logic         N,
  output logic         Z,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [n-1:0]   sa;
  logic [n-1:0]   sb;
  logic [n-2:0]   pr;
  logic [n-1:0]   pr_nxt;
  logic           br;
  logic           br_nxt;
  logic           d;
  logic [CW-1:0]  cnt;
  logic           a_msb;
  logic           b_msb;
  logic           accept;
  logic           last_bit;

  assign accept   = start && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (cnt == CW'(n - 1));

  // One full-subtractor cell; the new bit enters the partial result from the MSB side.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign pr_nxt = {d, pr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      pr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      res   <= '0;
      baOut <= 1'b0;
      N     <= 1'b0;
      Z     <= 1'b1;
      V     <= 1'b0;
    end else if (accept) begin
      sa    <= A;
      sb    <= B;
      a_msb <= A[n-1];
      b_msb <= B[n-1];
      pr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      pr  <= pr_nxt[n-1:1];
      br  <= br_nxt;
      cnt <= cnt + CW'(1);
      // The last bit goes straight into res so all flags publish on the same edge.
      if (last_bit) begin
        res   <= pr_nxt;
        baOut <= br_nxt;
        N     <= d;
        Z     <= (pr_nxt == '0);
        V     <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

endmodule
